// File: rtl/hqa_norm_acc.sv
// Sum of squared magnitudes over two captured 4-element complex columns.
// One element per cycle after capture; the result is held until the consumer acknowledges it.
module hqa_norm_acc #(
    parameter int DW = 16,
    parameter int QF = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*DW-1:0]   col0_r,
    input  logic [4*DW-1:0]   col0_i,
    input  logic [4*DW-1:0]   col1_r,
    input  logic [4*DW-1:0]   col1_i,
    input  logic              ready,
    input  logic              out_ack,
    output logic [2*DW+2:0]   norm_full,
    output logic [DW-1:0]     norm_q,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    // Sixteen squares of at most 2^(2*DW-2) each need 2*DW+3 bits.
    localparam int NW = 2 * DW + 3;
    localparam logic [NW-QF-1:0] QMAX = {{(NW-QF-DW+1){1'b0}}, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                 ready_q;
    logic                 rise;
    logic [2:0]           idx_q;
    logic [NW-1:0]        acc_q;
    logic [4*DW-1:0]      cap0_r, cap0_i, cap1_r, cap1_i;
    logic [NW-1:0]        norm_full_q;
    logic [DW-1:0]        norm_q_q;
    logic                 overrun_q;

    logic [DW-1:0]        re_sel, im_sel;
    logic signed [2*DW-1:0] re_ext, im_ext;
    logic signed [2*DW-1:0] re_sq, im_sq;
    logic [NW-1:0]        re_term, im_term;
    logic [NW-1:0]        acc_sum;
    logic [NW-QF-1:0]     sum_hi;
    logic [DW-1:0]        q_val;

    // Element k of a packed column sits at the most significant end for k = 0.
    function automatic logic [DW-1:0] lane(input logic [4*DW-1:0] bus, input logic [1:0] k);
        logic [DW-1:0] v;
        v = '0;
        case (k)
            2'd0:    v = bus[4*DW-1 -: DW];
            2'd1:    v = bus[3*DW-1 -: DW];
            2'd2:    v = bus[2*DW-1 -: DW];
            default: v = bus[DW-1:0];
        endcase
        return v;
    endfunction

    assign rise = ready & ~ready_q;

    // Datapath: current element, its squared magnitude, running sum and Q-format view.
    always_comb begin
        re_sel  = idx_q[2] ? lane(cap1_r, idx_q[1:0]) : lane(cap0_r, idx_q[1:0]);
        im_sel  = idx_q[2] ? lane(cap1_i, idx_q[1:0]) : lane(cap0_i, idx_q[1:0]);
        re_ext  = {{DW{re_sel[DW-1]}}, re_sel};
        im_ext  = {{DW{im_sel[DW-1]}}, im_sel};
        re_sq   = re_ext * re_ext;
        im_sq   = im_ext * im_ext;
        re_term = {{(NW-2*DW){1'b0}}, re_sq};
        im_term = {{(NW-2*DW){1'b0}}, im_sq};
        acc_sum = acc_q + re_term + im_term;
        sum_hi  = acc_sum[NW-1:QF];
        q_val   = (sum_hi > QMAX) ? QMAX[DW-1:0] : acc_sum[QF+DW-1:QF];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rise) state_d = S_ACC;
            S_ACC:  if (idx_q == 3'd7) state_d = S_DONE;
            S_DONE: if (out_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q     <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            cap0_r      <= '0;
            cap0_i      <= '0;
            cap1_r      <= '0;
            cap1_i      <= '0;
            norm_full_q <= '0;
            norm_q_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            ready_q <= ready;
            // A new product request is dropped, not queued, while one is in flight or held.
            if (rise && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        cap0_r <= col0_r;
                        cap0_i <= col0_i;
                        cap1_r <= col1_r;
                        cap1_i <= col1_i;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                S_ACC: begin
                    acc_q <= acc_sum;
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        norm_full_q <= acc_sum;
                        norm_q_q    <= q_val;
                    end
                end
                default: ;
            endcase
        end
    end

    // out_valid stays high until out_ack is sampled high on a rising edge; ack is ignored otherwise.
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign norm_full = norm_full_q;
    assign norm_q    = norm_q_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hqa_norm_acc.sv
// Bench for hqa_norm_acc: directed cases plus randomized traffic against a behavioural model.
module tb_hqa_norm_acc;

    localparam int DW = 16;
    localparam int QF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] col0_r = '0, col0_i = '0, col1_r = '0, col1_i = '0;
    logic        ready = 1'b0, out_ack = 1'b0;
    logic [34:0] norm_full;
    logic [15:0] norm_q;
    logic        out_valid, busy, overrun;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    hqa_norm_acc #(.DW(DW), .QF(QF)) dut (
        .clk(clk), .rst(rst),
        .col0_r(col0_r), .col0_i(col0_i), .col1_r(col1_r), .col1_i(col1_i),
        .ready(ready), .out_ack(out_ack),
        .norm_full(norm_full), .norm_q(norm_q),
        .out_valid(out_valid), .busy(busy), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic.
    function automatic longint lane_sq(input logic [63:0] bus, input int k);
        logic [63:0] sh;
        shortint     x;
        sh = bus >> (48 - 16 * k);
        x  = shortint'(sh[15:0]);
        return longint'(x) * longint'(x);
    endfunction

    function automatic longint ref_norm(input logic [63:0] a, b, c, d);
        longint s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s += lane_sq(a, k) + lane_sq(b, k) + lane_sq(c, k) + lane_sq(d, k);
        end
        return s;
    endfunction

    function automatic logic [15:0] ref_q(input longint s);
        longint t;
        t = s / (64'sd1 << QF);
        if (t > 32767) return 16'h7FFF;
        return 16'(t);
    endfunction

    function automatic logic [63:0] rand_bus(input int mode);
        logic [63:0] v;
        logic [15:0] l;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            case (mode)
                0:       l = 16'($urandom_range(0, 511) - 256);
                1:       l = 16'($urandom_range(0, 65535));
                default: begin
                    case ($urandom_range(0, 3))
                        0:       l = 16'h8000;
                        1:       l = 16'h7FFF;
                        2:       l = 16'hFFFF;
                        default: l = 16'h0000;
                    endcase
                end
            endcase
            v = (v << 16) | {48'd0, l};
        end
        return v;
    endfunction

    // Behavioural model: a request latches a result due 8 edges later, held until acked.
    logic        m_prev = 1'b0;
    logic        m_rise;
    int          m_remaining = 0;
    bit          m_hold = 0;
    bit          m_ovr = 0;
    logic [34:0] m_pending = '0, m_norm = '0;
    logic [15:0] m_q = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prev = 1'b0; m_remaining = 0; m_hold = 0; m_ovr = 0;
            m_norm = '0; m_q = '0;
        end else begin
            m_rise = ready && !m_prev;
            m_prev = ready;
            if (m_hold) begin
                if (m_rise) m_ovr = 1;
                if (out_ack) m_hold = 0;
            end else if (m_remaining > 0) begin
                if (m_rise) m_ovr = 1;
                m_remaining--;
                if (m_remaining == 0) begin
                    m_hold = 1;
                    m_norm = m_pending;
                    m_q    = ref_q(longint'(m_pending));
                end
            end else if (m_rise) begin
                m_pending   = 35'(ref_norm(col0_r, col0_i, col1_r, col1_i));
                m_remaining = 8;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("out_valid", 64'(out_valid), 64'(m_hold));
            check("busy", 64'(busy), 64'(m_hold || (m_remaining > 0)));
            check("overrun", 64'(overrun), 64'(m_ovr));
            check("norm_full", 64'(norm_full), 64'(m_norm));
            check("norm_q", 64'(norm_q), 64'(m_q));
        end
    end

    task automatic set_cols(input logic [63:0] a, b, c, d);
        col0_r = a; col0_i = b; col1_r = c; col1_i = d;
    endtask

    task automatic run_op(input string name);
        int lat;
        lat = 0;
        ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) ready = 1'b0;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'd9);
    endtask

    task automatic do_ack();
        out_ack = 1'b1;
        @(posedge clk); #1;
        out_ack = 1'b0;
        check("ack_clears_valid", 64'(out_valid), 64'd0);
    endtask

    logic [63:0] a0, a1, a2, a3;
    int          episodes;
    bit          prev_v;

    initial begin
        #3;
        check("rst_norm_full", 64'(norm_full), 64'd0);
        check("rst_norm_q", 64'(norm_q), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        set_cols({4{16'h0100}}, 64'd0, 64'd0, 64'd0);
        run_op("unit_lanes");
        check("unit_lanes_full", 64'(norm_full), 64'h40000);
        check("unit_lanes_q", 64'(norm_q), 64'h0400);
        check("model_pin_unit", 64'(m_norm), 64'h40000);
        do_ack();

        set_cols({4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}});
        run_op("all_min");
        check("all_min_full", 64'(norm_full), 64'h4_0000_0000);
        check("all_min_q", 64'(norm_q), 64'h7FFF);
        check("model_pin_sat", 64'(m_q), 64'h7FFF);
        do_ack();

        // (-35)^2 + 193^2 = 0x4C9 + 0x9181
        set_cols(64'hFFDD_0000_0000_0000, 64'h00C1_0000_0000_0000, 64'd0, 64'd0);
        run_op("single");
        check("single_full", 64'(norm_full), 64'h964A);
        check("single_q", 64'(norm_q), 64'h0096);
        do_ack();
        repeat (3) @(posedge clk);
        #1 check("idle_retains", 64'(norm_full), 64'h964A);

        set_cols(rand_bus(0), rand_bus(0), rand_bus(0), rand_bus(0));
        episodes = 0; prev_v = 0;
        ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid && !prev_v) episodes++;
            prev_v  = out_valid;
            out_ack = out_valid;
        end
        out_ack = 1'b0;
        ready   = 1'b0;
        check("held_ready_episodes", 64'(episodes), 64'd1);
        check("held_ready_overrun", 64'(overrun), 64'd0);
        @(posedge clk); #1;

        a0 = rand_bus(1); a1 = rand_bus(1); a2 = rand_bus(0); a3 = rand_bus(0);
        set_cols(a0, a1, a2, a3);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        set_cols(rand_bus(1), rand_bus(1), rand_bus(1), rand_bus(1));
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        for (int k = 0; k < 20 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("overrun_valid", 64'(out_valid), 64'd1);
        check("overrun_result", 64'(norm_full), 64'(35'(ref_norm(a0, a1, a2, a3))));
        check("overrun_flag", 64'(overrun), 64'd1);
        ready = 1'b0;
        do_ack();

        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_overrun", 64'(overrun), 64'd0);
        check("abort_norm_full", 64'(norm_full), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        a0 = rand_bus(0); a1 = rand_bus(0); a2 = rand_bus(0); a3 = rand_bus(0);
        set_cols(a0, a1, a2, a3);
        run_op("after_abort");
        check("after_abort_full", 64'(norm_full), 64'(35'(ref_norm(a0, a1, a2, a3))));
        check("after_abort_q", 64'(norm_q), 64'(ref_q(ref_norm(a0, a1, a2, a3))));
        do_ack();

        for (int i = 0; i < 900; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) ready = ~ready;
            out_ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                int mode;
                mode = $urandom_range(0, 2);
                set_cols(rand_bus(mode), rand_bus(mode), rand_bus(mode), rand_bus(mode));
            end
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b0;
                #1 rst = 1'b1;
            end
        end
        ready = 1'b0;
        out_ack = 1'b1;
        repeat (12) @(posedge clk);
        #1 out_ack = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
